// File: rtl/io_event_flag_if.sv
// Bundle between the event front end and the CPU-side status logic: raw event line,
// read-acknowledge strobe, sticky flag and event pulse. OVERRUN exists only when IO_EVENT_OVERRUN_EN is defined.
interface io_event_flag_if;
    logic evt_in;
    logic rd_ack;
    logic flag;
    logic evt_pulse;
`ifdef IO_EVENT_OVERRUN_EN
    logic overrun;
`endif

    modport master (
        output evt_in,
        output rd_ack,
        input  flag,
        input  evt_pulse
`ifdef IO_EVENT_OVERRUN_EN
        ,
        input  overrun
`endif
    );

    modport slave (
        input  evt_in,
        input  rd_ack,
        output flag,
        output evt_pulse
`ifdef IO_EVENT_OVERRUN_EN
        ,
        output overrun
`endif
    );
endinterface

// File: rtl/io_event_flag.sv
// Synchronises and debounces a raw I/O event line into a sticky status flag cleared by a bus read.
// Optional IO_EVENT_OVERRUN_EN adds a sticky OVERRUN bit for events that arrive while FLAG is still set.
module io_event_flag #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 3
) (
    input logic           clk,
    input logic           rst_n,
    io_event_flag_if.slave bus
);

    typedef enum logic [1:0] {
        LOW_STABLE,
        QUAL_HIGH,
        HIGH_STABLE,
        QUAL_LOW
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] cnt;
    state_t           state;
    logic             accept;

    // A rising event is accepted on the QUAL_HIGH -> HIGH_STABLE transition only.
    assign accept = (state == QUAL_HIGH) && sync2 && (cnt == CNT_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1         <= 1'b0;
            sync2         <= 1'b0;
            cnt           <= '0;
            state         <= LOW_STABLE;
            bus.flag      <= 1'b0;
            bus.evt_pulse <= 1'b0;
`ifdef IO_EVENT_OVERRUN_EN
            bus.overrun   <= 1'b0;
`endif
        end else begin
            sync1 <= bus.evt_in;
            sync2 <= sync1;

            case (state)
                LOW_STABLE: begin
                    if (sync2) begin
                        state <= QUAL_HIGH;
                        cnt   <= CNT_ONE;
                    end else begin
                        cnt   <= '0;
                    end
                end
                QUAL_HIGH: begin
                    if (!sync2) begin
                        state <= LOW_STABLE;
                        cnt   <= '0;
                    end else if (cnt == CNT_MAX) begin
                        state <= HIGH_STABLE;
                        cnt   <= '0;
                    end else begin
                        cnt   <= cnt + CNT_ONE;
                    end
                end
                HIGH_STABLE: begin
                    if (!sync2) begin
                        state <= QUAL_LOW;
                        cnt   <= CNT_ONE;
                    end else begin
                        cnt   <= '0;
                    end
                end
                QUAL_LOW: begin
                    if (sync2) begin
                        state <= HIGH_STABLE;
                        cnt   <= '0;
                    end else if (cnt == CNT_MAX) begin
                        state <= LOW_STABLE;
                        cnt   <= '0;
                    end else begin
                        cnt   <= cnt + CNT_ONE;
                    end
                end
                default: begin
                    state <= LOW_STABLE;
                    cnt   <= '0;
                end
            endcase

            // Set beats clear so an event coinciding with a read is never lost.
            bus.evt_pulse <= accept;
            bus.flag      <= accept | (bus.flag & ~bus.rd_ack);
`ifdef IO_EVENT_OVERRUN_EN
            bus.overrun   <= (accept & bus.flag & ~bus.rd_ack) | (bus.overrun & ~bus.rd_ack);
`endif
        end
    end

endmodule

// File: tb/tb_io_event_flag.sv
// Self-checking bench for io_event_flag: directed scenarios plus randomized line activity,
// compared against a run-length reference model of the debounce and flag rules.
module tb_io_event_flag;

    localparam int D = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    io_event_flag_if bus ();

    io_event_flag #(
        .DEBOUNCE_CYCLES(D),
        .CNT_W          (3)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: accepted level flips after D+1 consecutive synchronised samples that disagree with it.
    bit m_s1, m_s2, m_level, m_flag, m_pulse, m_ovr;
    int m_run;

    task automatic model_reset();
        m_s1 = 0; m_s2 = 0; m_level = 0; m_run = 0;
        m_flag = 0; m_pulse = 0; m_ovr = 0;
    endtask

    task automatic model_edge(input bit evt, input bit ack);
        bit acc;
        acc = 0;
        if (m_s2 != m_level) m_run = m_run + 1;
        else                 m_run = 0;
        if (m_run == D + 1) begin
            m_level = ~m_level;
            m_run   = 0;
            acc     = m_level;
        end
        m_ovr   = (acc && m_flag && !ack) ? 1'b1 : (ack ? 1'b0 : m_ovr);
        m_flag  = acc ? 1'b1 : (ack ? 1'b0 : m_flag);
        m_pulse = acc;
        m_s2    = m_s1;
        m_s1    = evt;
    endtask

    task automatic check_output(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        check_output("flag_model", bus.flag, m_flag);
        check_output("pulse_model", bus.evt_pulse, m_pulse);
`ifdef IO_EVENT_OVERRUN_EN
        check_output("overrun_model", bus.overrun, m_ovr);
`endif
    endtask

    task automatic apply_stimulus(input logic evt, input logic ack);
        bus.evt_in = evt;
        bus.rd_ack = ack;
        model_edge(evt, ack);
        @(posedge clk);
        #1;
        check_model();
    endtask

    initial begin
        bus.evt_in = 1'b0;
        bus.rd_ack = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_output("reset_flag", bus.flag, 1'b0);
        check_output("reset_pulse", bus.evt_pulse, 1'b0);
        rst_n = 1'b1;
        repeat (3) apply_stimulus(1'b0, 1'b0);

        // Held-high line: pulse only after edge 6, flag from edge 6 on.
        for (int k = 0; k <= 9; k++) begin
            apply_stimulus(1'b1, 1'b0);
            check_output("lat_pulse", bus.evt_pulse, (k == 6) ? 1'b1 : 1'b0);
            check_output("lat_flag", bus.flag, (k >= 6) ? 1'b1 : 1'b0);
        end

        // Read clears the flag; a second read changes nothing; held line gives no new event.
        apply_stimulus(1'b1, 1'b1);
        check_output("ack_clear", bus.flag, 1'b0);
        apply_stimulus(1'b1, 1'b1);
        check_output("ack_again", bus.flag, 1'b0);
        for (int k = 0; k < 6; k++) begin
            apply_stimulus(1'b1, 1'b0);
            check_output("held_no_event", bus.flag, 1'b0);
        end

        // Short glitch is rejected.
        repeat (8) apply_stimulus(1'b0, 1'b0);
        for (int k = 0; k < 11; k++) begin
            apply_stimulus((k < 3) ? 1'b1 : 1'b0, 1'b0);
            check_output("glitch_flag", bus.flag, 1'b0);
            check_output("glitch_pulse", bus.evt_pulse, 1'b0);
        end

        // Read in the same cycle as an accepted event: set wins.
        for (int k = 0; k <= 7; k++) begin
            apply_stimulus(1'b1, (k == 6) ? 1'b1 : 1'b0);
            if (k == 6) begin
                check_output("setwin_flag", bus.flag, 1'b1);
                check_output("setwin_pulse", bus.evt_pulse, 1'b1);
            end
        end
        check_output("setwin_pulse_end", bus.evt_pulse, 1'b0);

        // Second event while the flag is still set.
        repeat (8) apply_stimulus(1'b0, 1'b0);
        for (int k = 0; k <= 7; k++) apply_stimulus(1'b1, 1'b0);
        check_output("second_flag", bus.flag, 1'b1);
`ifdef IO_EVENT_OVERRUN_EN
        check_output("overrun_set", bus.overrun, 1'b1);
`endif
        apply_stimulus(1'b1, 1'b1);
        check_output("second_clear", bus.flag, 1'b0);
`ifdef IO_EVENT_OVERRUN_EN
        check_output("overrun_clear", bus.overrun, 1'b0);
`endif

        // Asynchronous reset with the flag set, then a still-high line is a fresh event.
        repeat (8) apply_stimulus(1'b0, 1'b0);
        for (int k = 0; k <= 7; k++) apply_stimulus(1'b1, 1'b0);
        check_output("pre_reset_flag", bus.flag, 1'b1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_output("async_reset_flag", bus.flag, 1'b0);
        check_output("async_reset_pulse", bus.evt_pulse, 1'b0);
`ifdef IO_EVENT_OVERRUN_EN
        check_output("async_reset_overrun", bus.overrun, 1'b0);
`endif
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k <= 7; k++) begin
            apply_stimulus(1'b1, 1'b0);
            check_output("fresh_pulse", bus.evt_pulse, (k == 6) ? 1'b1 : 1'b0);
        end

        // Randomized runs of random length with sporadic reads.
        begin
            logic lvl;
            int   len;
            lvl = 1'b0;
            for (int r = 0; r < 120; r++) begin
                lvl = ~lvl;
                len = $urandom_range(1, 9);
                for (int k = 0; k < len; k++)
                    apply_stimulus(lvl, ($urandom_range(0, 7) == 0) ? 1'b1 : 1'b0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
